// File: rtl/cam_frame_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cam_frame_capture
// Front-end capture stage for an OV7670 camera port. The camera byte stream is
// oversampled in the system clock domain. Byte pairs (RGB565) are reduced to
// RGB332 and written into a frame buffer at row*IMG_W + col. Frame completion
// and frame integrity are reported downstream.
//
// Ports
//   clk          system clock, at least 4x the camera pixel clock
//   CAM_reset    asynchronous reset, active-high
//   CAM_pclk     camera pixel clock, sampled as data
//   CAM_vsync    high = vertical blanking, falling edge starts a frame
//   CAM_href     high while active line bytes are presented
//   CAM_px_data  camera byte (even = RRRRRGGG, odd = GGGBBBBB)
//   mem_addr     frame-buffer write address
//   mem_data     RGB332 pixel {R[4:2], G[5:3], B[4:3]}
//   mem_we       one-clock write strobe
//   frame_done   one-clock pulse when an active frame ends (vsync rising)
//   frame_ok     valid with frame_done: all IMG_H rows seen, no line errors
//   err_line     sticky line-error flag, cleared at frame start
//
// Optional feature: define COLOR_COUNT_EN to add red_cnt/green_cnt/blue_cnt,
// per-frame counts of written pixels classified by dominant colour.
// -----------------------------------------------------------------------------
module cam_frame_capture #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          CAM_reset,
    input  logic          CAM_pclk,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_we,
    output logic          frame_done,
    output logic          frame_ok,
`ifdef COLOR_COUNT_EN
    output logic          err_line,
    output logic [AW-1:0] red_cnt,
    output logic [AW-1:0] green_cnt,
    output logic [AW-1:0] blue_cnt
`else
    output logic          err_line
`endif
);

    localparam logic [1:0] S_WAIT_BLANK = 2'd0;
    localparam logic [1:0] S_WAIT_FRAME = 2'd1;
    localparam logic [1:0] S_ACTIVE     = 2'd2;

    localparam logic [7:0] LP_W          = 8'(IMG_W);
    localparam logic [7:0] LP_H          = 8'(IMG_H);
    localparam logic [9:0] LP_LINE_BYTES = 10'(2 * IMG_W);

    // RGB565 byte pair to RGB332: keep the top bits of each channel.
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    // Synchronizer and alignment stages
    logic       r_pclk_m, r_pclk_s, r_pclk_d;
    logic       r_vsync_m, r_vsync_s, r_href_m, r_href_s;
    logic [7:0] r_data_m, r_data_s;
    logic       r_rise_q, r_href_q, r_href_qd, r_vsync_q, r_vsync_qd;
    logic [7:0] r_byte_q;

    // Capture state
    logic [1:0] r_state;
    logic       r_phase, r_err, r_done, r_ok;
    logic [7:0] r_hi, r_row, r_col;
    logic [9:0] r_bytes;
    logic       r_pend;
    logic [7:0] r_pend_row, r_pend_col, r_pend_pix;

    logic        w_byte, w_href_fall, w_vs_rise, w_vs_fall;
    logic        w_line_close, w_line_bad, w_pix_in_frame, w_err_after;
    logic [7:0]  w_row_next, w_row_after;
    logic [15:0] w_addr_full;

    // Two-flop synchronizers for all camera inputs plus a third pclk flop for
    // edge detection; the edge strobe, href, vsync and the byte are then
    // re-registered together so every stream event shares one timeline.
    always_ff @(posedge clk or posedge CAM_reset) begin
        if (CAM_reset) begin
            r_pclk_m   <= 1'b0;
            r_pclk_s   <= 1'b0;
            r_pclk_d   <= 1'b0;
            r_vsync_m  <= 1'b0;
            r_vsync_s  <= 1'b0;
            r_href_m   <= 1'b0;
            r_href_s   <= 1'b0;
            r_data_m   <= 8'h00;
            r_data_s   <= 8'h00;
            r_rise_q   <= 1'b0;
            r_href_q   <= 1'b0;
            r_href_qd  <= 1'b0;
            r_vsync_q  <= 1'b0;
            r_vsync_qd <= 1'b0;
            r_byte_q   <= 8'h00;
        end else begin
            r_pclk_m   <= CAM_pclk;
            r_pclk_s   <= r_pclk_m;
            r_pclk_d   <= r_pclk_s;
            r_vsync_m  <= CAM_vsync;
            r_vsync_s  <= r_vsync_m;
            r_href_m   <= CAM_href;
            r_href_s   <= r_href_m;
            r_data_m   <= CAM_px_data;
            r_data_s   <= r_data_m;
            r_rise_q   <= r_pclk_s & ~r_pclk_d;
            r_href_q   <= r_href_s;
            r_href_qd  <= r_href_q;
            r_vsync_q  <= r_vsync_s;
            r_vsync_qd <= r_vsync_q;
            r_byte_q   <= r_data_s;
        end
    end

    // Stream events, line-close bookkeeping and write address arithmetic.
    always_comb begin
        w_byte         = r_rise_q & r_href_q;
        w_href_fall    = r_href_qd & ~r_href_q;
        w_vs_rise      = r_vsync_q & ~r_vsync_qd;
        w_vs_fall      = ~r_vsync_q & r_vsync_qd;
        // A frame ending while href is still high closes the line first.
        w_line_close   = w_href_fall | (w_vs_rise & r_href_q);
        w_line_bad     = (r_bytes != LP_LINE_BYTES) | (r_row >= LP_H);
        w_pix_in_frame = (r_col < LP_W) & (r_row < LP_H);
        if (r_row >= LP_H) begin
            w_row_next = LP_H;
        end else begin
            w_row_next = r_row + 8'd1;
        end
        if (w_line_close) begin
            w_row_after = w_row_next;
            w_err_after = r_err | w_line_bad;
        end else begin
            w_row_after = r_row;
            w_err_after = r_err;
        end
        w_addr_full = 16'(r_pend_row) * 16'(IMG_W) + 16'(r_pend_col);
    end

    // Frame/line state machine: byte pairing, row/col tracking, integrity.
    always_ff @(posedge clk or posedge CAM_reset) begin
        if (CAM_reset) begin
            r_state    <= S_WAIT_BLANK;
            r_phase    <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_hi       <= 8'h00;
            r_row      <= 8'h00;
            r_col      <= 8'h00;
            r_bytes    <= 10'd0;
            r_pend     <= 1'b0;
            r_pend_row <= 8'h00;
            r_pend_col <= 8'h00;
            r_pend_pix <= 8'h00;
        end else begin
            r_done <= 1'b0;
            r_pend <= 1'b0;
            case (r_state)
                S_WAIT_BLANK: begin
                    if (r_vsync_q) begin
                        r_state <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (w_vs_fall) begin
                        r_state <= S_ACTIVE;
                        r_row   <= 8'h00;
                        r_col   <= 8'h00;
                        r_err   <= 1'b0;
                        r_ok    <= 1'b0;
                        r_phase <= 1'b0;
                        r_bytes <= 10'd0;
                    end
                end
                S_ACTIVE: begin
                    if (w_line_close) begin
                        r_err   <= w_err_after;
                        r_row   <= w_row_next;
                        r_col   <= 8'h00;
                        r_phase <= 1'b0;
                        r_bytes <= 10'd0;
                    end else if (w_byte) begin
                        if (r_bytes != 10'h3FF) begin
                            r_bytes <= r_bytes + 10'd1;
                        end
                        if (!r_phase) begin
                            r_hi    <= r_byte_q;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            // Saturate so an overlong line never wraps back into range.
                            if (r_col != 8'hFF) begin
                                r_col <= r_col + 8'd1;
                            end
                            if (w_pix_in_frame) begin
                                r_pend     <= 1'b1;
                                r_pend_row <= r_row;
                                r_pend_col <= r_col;
                                r_pend_pix <= rgb565_to_332(r_hi, r_byte_q);
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    if (w_vs_rise) begin
                        r_state <= S_WAIT_FRAME;
                        r_done  <= 1'b1;
                        r_ok    <= (w_row_after == LP_H) & ~w_err_after;
                    end
                end
                default: begin
                    r_state <= S_WAIT_BLANK;
                end
            endcase
        end
    end

    // Registered frame-buffer write port.
    always_ff @(posedge clk or posedge CAM_reset) begin
        if (CAM_reset) begin
            mem_we   <= 1'b0;
            mem_data <= 8'h00;
            mem_addr <= '0;
        end else begin
            mem_we   <= r_pend;
            mem_data <= r_pend_pix;
            mem_addr <= AW'(w_addr_full);
        end
    end

    assign frame_done = r_done;
    assign frame_ok   = r_ok;
    assign err_line   = r_err;

`ifdef COLOR_COUNT_EN
    // 1 = red, 2 = green, 3 = blue, 0 = none. A channel is "high" when its
    // RGB332 field is in the upper half of its range.
    function automatic logic [1:0] color_class(input logic [7:0] pix);
        logic r_hi_s, g_hi_s, b_hi_s;
        r_hi_s = pix[7];
        g_hi_s = pix[4];
        b_hi_s = pix[1];
        if (r_hi_s & ~g_hi_s & ~b_hi_s) begin
            return 2'd1;
        end else if (g_hi_s & ~r_hi_s & ~b_hi_s) begin
            return 2'd2;
        end else if (b_hi_s & ~r_hi_s & ~g_hi_s) begin
            return 2'd3;
        end else begin
            return 2'd0;
        end
    endfunction

    // Per-frame colour counters, cleared at frame start; no writes occur
    // between frame_done and the next frame start, so they hold there.
    always_ff @(posedge clk or posedge CAM_reset) begin
        if (CAM_reset) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
        end else if ((r_state == S_WAIT_FRAME) && w_vs_fall) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
        end else if (r_pend) begin
            case (color_class(r_pend_pix))
                2'd1:    red_cnt   <= red_cnt + AW'(1);
                2'd2:    green_cnt <= green_cnt + AW'(1);
                2'd3:    blue_cnt  <= blue_cnt + AW'(1);
                default: red_cnt   <= red_cnt;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_cam_frame_capture.sv
`timescale 1ns/1ps
module tb_cam_frame_capture;

    localparam int W  = 160;
    localparam int H  = 7;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          CAM_reset, CAM_pclk, CAM_vsync, CAM_href;
    logic [7:0]    CAM_px_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we, frame_done, frame_ok, err_line;
`ifdef COLOR_COUNT_EN
    logic [AW-1:0] red_cnt, green_cnt, blue_cnt;
`endif

    always #5 clk = ~clk;

    cam_frame_capture #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk(clk), .CAM_reset(CAM_reset), .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync),
        .CAM_href(CAM_href), .CAM_px_data(CAM_px_data), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .frame_done(frame_done),
        .frame_ok(frame_ok),
`ifdef COLOR_COUNT_EN
        .err_line(err_line), .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt)
`else
        .err_line(err_line)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state
    int m_row, m_red, m_green, m_blue;
    bit m_err;
    bit m_dead = 1'b1;
    int         exp_addr[$];
    logic [7:0] exp_data[$];
    bit exp_fok[$], exp_ferr[$];
    int exp_r[$], exp_g[$], exp_b[$];

    // Observed statistics
    int wr_cnt, last_addr, fd_cnt, last_red;
    logic [7:0] last_data;
    bit last_ok, last_err;
    int row_wr[8];
    int row_min[8];
    int lat_cyc;
    bit lat_arm = 1'b0;

    function automatic logic [7:0] model_pix(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] word;
        logic [4:0]  r5, b5;
        logic [5:0]  g6;
        word = {hi, lo};
        r5 = word[15:11];
        g6 = word[10:5];
        b5 = word[4:0];
        return {r5[4:2], g6[5:3], b5[4:3]};
    endfunction

    task automatic count_color(input logic [7:0] pix);
        int r3, g3, b2;
        r3 = int'(pix) / 32;
        g3 = (int'(pix) / 4) % 8;
        b2 = int'(pix) % 4;
        if (r3 >= 4 && g3 < 4 && b2 < 2) m_red++;
        else if (g3 >= 4 && r3 < 4 && b2 < 2) m_green++;
        else if (b2 >= 2 && r3 < 4 && g3 < 4) m_blue++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0;
        fd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            row_wr[i]  = 0;
            row_min[i] = 32'h7FFF_FFFF;
        end
    endtask

    task automatic frame_start();
        CAM_vsync = 1'b1;
        tick(6);
        CAM_vsync = 1'b0;
        m_dead = 1'b0;
        m_row = 0; m_err = 1'b0;
        m_red = 0; m_green = 0; m_blue = 0;
        tick(6);
    endtask

    task automatic frame_end();
        CAM_vsync = 1'b1;
        if (!m_dead) begin
            exp_fok.push_back((m_row == H) && !m_err);
            exp_ferr.push_back(m_err);
            exp_r.push_back(m_red);
            exp_g.push_back(m_green);
            exp_b.push_back(m_blue);
        end
        tick(10);
    endtask

    task automatic drive_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                              input int reset_at, input bit arm);
        bit odd;
        int col;
        logic [7:0] pix;
        CAM_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            odd = (i % 2) == 1;
            CAM_pclk = 1'b0;
            CAM_px_data = odd ? lo : hi;
            tick(2);
            CAM_pclk = 1'b1;
            if (odd && !m_dead) begin
                col = i / 2;
                if (col < W && m_row < H) begin
                    pix = model_pix(hi, lo);
                    exp_addr.push_back(m_row * W + col);
                    exp_data.push_back(pix);
                    count_color(pix);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (arm && i == 1) begin
                lat_cyc = cyc;
                lat_arm = 1'b1;
            end
            tick(2);
            if (i == reset_at) begin
                CAM_reset = 1'b1;
                tick(3);
                CAM_reset = 1'b0;
                m_dead = 1'b1;
            end
        end
        CAM_pclk = 1'b0;
        CAM_href = 1'b0;
        tick(4);
        if (!m_dead) begin
            if (nbytes != 2 * W || m_row >= H) m_err = 1'b1;
            if (m_row < H) m_row++;
        end
    endtask

    // Compare process: every write and every frame_done against the model.
    initial begin
        int ea, r;
        logic [7:0] ed;
        forever begin
            @(negedge clk);
            if (!CAM_reset) begin
                if (mem_we) begin
                    wr_cnt++;
                    last_addr = int'(mem_addr);
                    last_data = mem_data;
                    r = int'(mem_addr) / W;
                    if (r < 8) begin
                        row_wr[r]++;
                        if (int'(mem_addr) < row_min[r]) row_min[r] = int'(mem_addr);
                    end
                    if (exp_addr.size() == 0) begin
                        check("spurious_we", int'(mem_we), 0);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        check("we_addr", int'(mem_addr), ea);
                        check("we_data", int'(mem_data), int'(ed));
                    end
                    if (lat_arm) begin
                        check("we_latency", cyc - lat_cyc, 5);
                        lat_arm = 1'b0;
                    end
                end
                if (frame_done) begin
                    fd_cnt++;
                    last_ok  = frame_ok;
                    last_err = err_line;
                    if (exp_fok.size() == 0) begin
                        check("spurious_done", int'(frame_done), 0);
                    end else begin
                        check("frame_ok", int'(frame_ok), int'(exp_fok.pop_front()));
                        check("err_line", int'(err_line), int'(exp_ferr.pop_front()));
`ifdef COLOR_COUNT_EN
                        last_red = int'(red_cnt);
                        check("red_cnt", int'(red_cnt), exp_r.pop_front());
                        check("green_cnt", int'(green_cnt), exp_g.pop_front());
                        check("blue_cnt", int'(blue_cnt), exp_b.pop_front());
`else
                        void'(exp_r.pop_front());
                        void'(exp_g.pop_front());
                        void'(exp_b.pop_front());
`endif
                    end
                end
            end
        end
    end

    initial begin
        CAM_reset = 1'b1; CAM_pclk = 1'b0; CAM_vsync = 1'b0;
        CAM_href = 1'b0; CAM_px_data = 8'h00;
        tick(20);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_ok", int'(frame_ok), 0);
        check("rst_err_line", int'(err_line), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        CAM_reset = 1'b0;
        tick(4);

        // Line while no frame has started: must not be captured.
        clear_stats();
        drive_line(2 * W, 8'h07, 8'hE0, -1, 1'b0);
        check("pre_frame_writes", wr_cnt, 0);

        // 1: full frame of green pixels.
        clear_stats();
        frame_start();
        for (int l = 0; l < H; l++) drive_line(2 * W, 8'h07, 8'hE0, -1, l == 0);
        frame_end();
        check("t1_writes", wr_cnt, 1120);
        check("t1_last_addr", last_addr, 1119);
        check("t1_last_data", int'(last_data), 8'h1C);
        check("t1_done_cnt", fd_cnt, 1);
        check("t1_ok", int'(last_ok), 1);
        check("t1_err", int'(last_err), 0);

        // 2: full frame of red pixels.
        clear_stats();
        frame_start();
        for (int l = 0; l < H; l++) drive_line(2 * W, 8'hF8, 8'h00, -1, 1'b0);
        frame_end();
        check("t2_last_data", int'(last_data), 8'hE0);
        check("t2_ok", int'(last_ok), 1);
`ifdef COLOR_COUNT_EN
        check("t2_red_cnt", last_red, 1120);
`endif

        // 3: line 5 carries 161 pixels.
        clear_stats();
        frame_start();
        for (int l = 0; l < H; l++) drive_line((l == 5) ? 2 * W + 2 : 2 * W, 8'hA5, 8'h3C, -1, 1'b0);
        frame_end();
        check("t3_row5_writes", row_wr[5], 160);
        check("t3_row6_writes", row_wr[6], 160);
        check("t3_row6_first", row_min[6], 960);
        check("t3_ok", int'(last_ok), 0);
        check("t3_err", int'(last_err), 1);

        // 4: line 2 of 319 bytes, plus one line beyond the frame height.
        clear_stats();
        frame_start();
        for (int l = 0; l < H + 1; l++) drive_line((l == 2) ? 2 * W - 1 : 2 * W, 8'h07, 8'hE0, -1, 1'b0);
        frame_end();
        check("t4_row2_writes", row_wr[2], 159);
        check("t4_row3_first", row_min[3], 480);
        check("t4_writes", wr_cnt, 1119);
        check("t4_ok", int'(last_ok), 0);
        check("t4_err", int'(last_err), 1);

        // 5: reset in the middle of line 4, then a clean frame.
        clear_stats();
        frame_start();
        for (int l = 0; l < 4; l++) drive_line(2 * W, 8'h00, 8'h1F, -1, 1'b0);
        drive_line(2 * W, 8'h00, 8'h1F, 40, 1'b0);
        drive_line(2 * W, 8'h00, 8'h1F, -1, 1'b0);
        frame_end();
        check("t5_partial_writes", wr_cnt, 660);
        check("t5_partial_done", fd_cnt, 0);
        clear_stats();
        frame_start();
        for (int l = 0; l < H; l++) drive_line(2 * W, 8'h00, 8'h1F, -1, 1'b0);
        frame_end();
        check("t5_writes", wr_cnt, 1120);
        check("t5_ok", int'(last_ok), 1);

        // 6: short frame with only 5 lines.
        clear_stats();
        frame_start();
        for (int l = 0; l < 5; l++) drive_line(2 * W, 8'h5A, 8'hC3, -1, 1'b0);
        frame_end();
        check("t6_done_cnt", fd_cnt, 1);
        check("t6_ok", int'(last_ok), 0);
        check("t6_err", int'(last_err), 0);

        tick(10);
        check("left_writes", exp_addr.size(), 0);
        check("left_frames", exp_fok.size(), 0);
        check("latency_seen", int'(lat_arm), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
